// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator over a raster pixel stream with K line buffers.
// Optional edge replication for pad_mode 10 is built only when WINGEN_EDGE_PAD_EN is defined.
module window_gen_kxk #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 256,
  parameter int K      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [7:0]                 img_width,
  input  logic [7:0]                 img_height,
  input  logic [1:0]                 pad_mode,
  input  logic                       stride,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [K*K*DATA_W-1:0]      out_window,
  output logic [7:0]                 out_row,
  output logic [7:0]                 out_col,
  output logic                       busy
);

  localparam int P  = (K - 1) / 2;
  localparam int AW = $clog2(MAX_W);
  localparam int LW = $clog2(K);
  localparam logic [9:0] KW  = 10'(K);
  localparam logic [9:0] PW  = 10'(P);
  localparam logic [9:0] PW1 = 10'(P + 1);
  localparam logic [9:0] MW  = 10'(MAX_W);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE
  } state_t;

  state_t            r_state;
  logic [9:0]        r_w, r_h, r_lim_r, r_lim_c;
  logic              r_pad, r_s2;
  logic [9:0]        r_in_r, r_in_c, r_pr, r_pc;
  logic [LW-1:0]     r_wl, r_pl;
  logic              r_end, r_ov, r_last;
  logic [K*K*DATA_W-1:0] r_win;
  logic [7:0]        r_orow, r_ocol;
  logic [DATA_W-1:0] r_lb [K][MAX_W];

`ifdef WINGEN_EDGE_PAD_EN
  logic r_rep;
  logic w_rep;
  assign w_rep = r_rep;
`else
  logic w_rep;
  assign w_rep = 1'b0;
`endif

  logic              w_act, w_gen, w_pad_in, w_bad;
  logic [9:0]        w_step, w_cap, w_pr_p, w_pc_p;
  logic [9:0]        w_br_r, w_br_c, w_nxt_pc, w_nxt_pr;
  logic              w_in_ready, w_in_fire, w_recv, w_avail;
  logic              w_load, w_ofire, w_last_pix, w_row_end, w_pos_last;
  logic [LW:0]       w_pl_sum;
  logic [LW-1:0]     w_pl_nxt;
  logic [K*K*DATA_W-1:0] w_taps;

  assign w_act    = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_gen    = w_act || (r_state == S_FLUSH);
  assign w_pad_in = (pad_mode != 2'b00);
  assign w_bad    = ({2'b0, img_width} < KW) || ({2'b0, img_width} > MW)
                 || ({2'b0, img_height} < KW) || ({2'b0, img_height} > MW);
  assign w_step   = r_s2 ? 10'd2 : 10'd1;

  // Oldest row still needed by the current position must not be overwritten.
  assign w_cap      = r_pad ? r_pr + PW1 : r_pr + KW;
  assign w_in_ready = w_act && (r_in_r < r_h) && (r_in_r < w_cap);
  assign w_in_fire  = w_in_ready && in_valid;

  assign w_pr_p = r_pr + PW;
  assign w_pc_p = r_pc + PW;
  assign w_br_r = r_pad ? ((w_pr_p >= r_h) ? r_h - 10'd1 : w_pr_p)
                        : r_pr + KW - 10'd1;
  assign w_br_c = r_pad ? ((w_pc_p >= r_w) ? r_w - 10'd1 : w_pc_p)
                        : r_pc + KW - 10'd1;

  assign w_recv = (r_in_r > w_br_r)
               || ((r_in_r == w_br_r)
                   && ((r_in_c > w_br_c)
                       || (w_in_fire && (r_in_c == w_br_c))));
  assign w_avail = w_gen && !r_end && w_recv;
  assign w_load  = w_avail && (!r_ov || out_ready);
  assign w_ofire = r_ov && out_ready;

  assign w_last_pix = w_in_fire && (r_in_r == r_h - 10'd1)
                   && (r_in_c == r_w - 10'd1);
  assign w_nxt_pc   = r_pc + w_step;
  assign w_nxt_pr   = r_pr + w_step;
  assign w_row_end  = (w_nxt_pc >= r_lim_c);
  assign w_pos_last = w_row_end && (w_nxt_pr >= r_lim_r);

  assign w_pl_sum = {1'b0, r_pl} + (r_s2 ? (LW+1)'(2) : (LW+1)'(1));
  assign w_pl_nxt = (w_pl_sum >= (LW+1)'(K))
                  ? LW'(w_pl_sum - (LW+1)'(K)) : w_pl_sum[LW-1:0];

  // Taps are clamped for addressing; the pixel being accepted is bypassed.
  always_comb begin
    int tr, tc, vi;
    logic oob, hit;
    logic [DATA_W-1:0] pix;
    w_taps = '0;
    tr = 0; tc = 0; vi = 0;
    oob = 1'b0; hit = 1'b0; pix = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        tr = int'(r_pr) + i - (r_pad ? P : 0);
        tc = int'(r_pc) + j - (r_pad ? P : 0);
        oob = (tr < 0) || (tr >= int'(r_h))
           || (tc < 0) || (tc >= int'(r_w));
        if (tr < 0) tr = 0;
        else if (tr >= int'(r_h)) tr = int'(r_h) - 1;
        if (tc < 0) tc = 0;
        else if (tc >= int'(r_w)) tc = int'(r_w) - 1;
        vi = int'(r_pl) + (tr - int'(r_pr)) + K;
        if (vi >= K) vi = vi - K;
        if (vi >= K) vi = vi - K;
        hit = w_in_fire && (tr == int'(r_in_r)) && (tc == int'(r_in_c));
        pix = hit ? in_data : r_lb[vi[LW-1:0]][tc[AW-1:0]];
        w_taps[(i*K+j)*DATA_W +: DATA_W] = (oob && !w_rep) ? '0 : pix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_lb[r_wl][r_in_c[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_lim_r <= '0;
      r_lim_c <= '0;
      r_pad   <= 1'b0;
`ifdef WINGEN_EDGE_PAD_EN
      r_rep   <= 1'b0;
`endif
      r_s2    <= 1'b0;
      r_in_r  <= '0;
      r_in_c  <= '0;
      r_pr    <= '0;
      r_pc    <= '0;
      r_wl    <= '0;
      r_pl    <= '0;
      r_end   <= 1'b0;
      r_ov    <= 1'b0;
      r_last  <= 1'b0;
      r_win   <= '0;
      r_orow  <= '0;
      r_ocol  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ov <= 1'b0;
          if (start) begin
            r_w     <= {2'b0, img_width};
            r_h     <= {2'b0, img_height};
            r_pad   <= w_pad_in;
`ifdef WINGEN_EDGE_PAD_EN
            r_rep   <= (pad_mode == 2'b10);
`endif
            r_s2    <= stride;
            r_lim_c <= w_pad_in ? {2'b0, img_width}
                                : {2'b0, img_width} - KW + 10'd1;
            r_lim_r <= w_pad_in ? {2'b0, img_height}
                                : {2'b0, img_height} - KW + 10'd1;
            r_in_r  <= '0;
            r_in_c  <= '0;
            r_pr    <= '0;
            r_pc    <= '0;
            r_wl    <= '0;
            r_pl    <= '0;
            r_end   <= 1'b0;
            r_last  <= 1'b0;
            r_state <= w_bad ? S_DONE : S_FILL;
          end
        end
        S_FILL, S_RUN, S_FLUSH: begin
          if (w_in_fire) begin
            if (r_in_c == r_w - 10'd1) begin
              r_in_c <= '0;
              r_in_r <= r_in_r + 10'd1;
              r_wl   <= (r_wl == LW'(K - 1)) ? '0 : r_wl + 1'b1;
            end else begin
              r_in_c <= r_in_c + 10'd1;
            end
          end
          if (w_load) begin
            r_win  <= w_taps;
            r_orow <= r_pr[7:0];
            r_ocol <= r_pc[7:0];
            r_ov   <= 1'b1;
            r_last <= w_pos_last;
            if (w_pos_last) r_end <= 1'b1;
            if (w_row_end) begin
              r_pc <= '0;
              r_pr <= w_nxt_pr;
              r_pl <= w_pl_nxt;
            end else begin
              r_pc <= w_nxt_pc;
            end
          end else if (w_ofire) begin
            r_ov <= 1'b0;
          end
          if (w_ofire && r_last)
            r_state <= S_DONE;
          else if ((r_state == S_FILL) && w_avail)
            r_state <= S_RUN;
          else if ((r_state == S_RUN) && r_pad && w_last_pix)
            r_state <= S_FLUSH;
        end
        S_DONE: begin
          r_ov    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_ov;
  assign out_window = r_win;
  assign out_row    = r_orow;
  assign out_col    = r_ocol;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: K=3 and K=5 instances against a behavioural window model.
// Directed ramp frames, random-stall frames, illegal sizes and a mid-frame reset abort.
module tb_window_gen_kxk;
  localparam int MW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start3, start5, stride, in_valid, out_ready, sel5;
  logic [7:0] img_width, img_height, in_data;
  logic [1:0] pad_mode;
  logic ir3, ov3, bz3, ir5, ov5, bz5;
  logic [71:0] win3;
  logic [199:0] win5;
  logic [7:0] row3, col3, row5, col5;
  logic w_ir, w_ov, w_bz;
  logic [199:0] w_win;
  logic [7:0] w_row, w_col;

  window_gen_kxk #(.DATA_W(8), .MAX_W(MW), .K(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .img_width(img_width), .img_height(img_height),
    .pad_mode(pad_mode), .stride(stride),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir3),
    .out_valid(ov3), .out_ready(out_ready), .out_window(win3),
    .out_row(row3), .out_col(col3), .busy(bz3));

  window_gen_kxk #(.DATA_W(8), .MAX_W(MW), .K(5)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start5),
    .img_width(img_width), .img_height(img_height),
    .pad_mode(pad_mode), .stride(stride),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir5),
    .out_valid(ov5), .out_ready(out_ready), .out_window(win5),
    .out_row(row5), .out_col(col5), .busy(bz5));

  always_comb begin
    w_ir  = sel5 ? ir5 : ir3;
    w_ov  = sel5 ? ov5 : ov3;
    w_bz  = sel5 ? bz5 : bz3;
    w_win = sel5 ? win5 : {128'b0, win3};
    w_row = sel5 ? row5 : row3;
    w_col = sel5 ? col5 : col3;
  end

  int n_assert = 0;
  int n_fail = 0;
  int img [0:39][0:39];
  logic [199:0] first_win, last_win;
  int last_row, last_col;

  task automatic chk(input string tag, input logic [199:0] obs,
                     input logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] p9(input int a0, a1, a2, a3, a4,
                                      a5, a6, a7, a8);
    int v [9];
    logic [199:0] r;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4;
    v[5] = a5; v[6] = a6; v[7] = a7; v[8] = a8;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[i][7:0];
    return r;
  endfunction

  // Window centred (padded) or anchored (unpadded) at (pr,pc).
  function automatic logic [199:0] exp_win(input int k, w, h, pad,
                                           pr, pc);
    logic [199:0] r;
    int off, rr, cc, rep, v;
    off = (pad != 0) ? (k - 1) / 2 : 0;
`ifdef WINGEN_EDGE_PAD_EN
    rep = (pad == 2) ? 1 : 0;
`else
    rep = 0;
`endif
    r = '0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        rr = pr + i - off;
        cc = pc + j - off;
        if (rr < 0 || rr >= h || cc < 0 || cc >= w) begin
          if (rep != 0) begin
            rr = (rr < 0) ? 0 : (rr >= h) ? h - 1 : rr;
            cc = (cc < 0) ? 0 : (cc >= w) ? w - 1 : cc;
            v = img[rr][cc];
          end else begin
            v = 0;
          end
        end else begin
          v = img[rr][cc];
        end
        r[(i*k+j)*8 +: 8] = v[7:0];
      end
    end
    return r;
  endfunction

  task automatic fill_ramp(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) img[r][c] = r * w + c;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 40; r++)
      for (int c = 0; c < 40; c++) img[r][c] = $urandom_range(0, 255);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ov"}, {199'b0, w_ov}, '0);
    chk({tag, "_ir"}, {199'b0, w_ir}, '0);
    chk({tag, "_busy"}, {199'b0, w_bz}, '0);
    chk({tag, "_win"}, w_win, '0);
    chk({tag, "_pos"}, {184'b0, w_row, w_col}, '0);
  endtask

  task automatic run_frame(input int k, input int w, input int h,
                           input int pad, input int s, input int rdy,
                           input int vld, input int abort_n,
                           output int got);
    int qr[$], qc[$];
    logic [199:0] qw[$];
    int step, limr, limc, px, total;
    bit stall, fin, ifire, ofire;
    logic [199:0] pw;
    logic [7:0] prow, pcol;
    step = (s != 0) ? 2 : 1;
    limr = (pad != 0) ? h : h - k + 1;
    limc = (pad != 0) ? w : w - k + 1;
    if (w >= k && h >= k && w <= MW && h <= MW) begin
      for (int r = 0; r < limr; r += step)
        for (int c = 0; c < limc; c += step) begin
          qr.push_back(r);
          qc.push_back(c);
          qw.push_back(exp_win(k, w, h, pad, r, c));
        end
    end
    total = qw.size();
    got = 0; px = 0; stall = 1'b0; fin = 1'b0;
    pw = '0; prow = '0; pcol = '0;
    @(negedge clk);
    sel5 = (k == 5);
    img_width = w[7:0];
    img_height = h[7:0];
    pad_mode = pad[1:0];
    stride = s[0];
    if (k == 5) start5 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0; start5 = 1'b0;
    img_width = 8'($urandom);
    img_height = 8'($urandom);
    pad_mode = 2'($urandom);
    stride = 1'($urandom);
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      start3 = 1'b0; start5 = 1'b0;
      if (stall) begin
        chk("stall_win", w_win, pw);
        chk("stall_pos", {184'b0, w_row, w_col}, {184'b0, prow, pcol});
      end
      if (cyc == 3 && w_bz) begin
        if (k == 5) start5 = 1'b1; else start3 = 1'b1;
      end
      in_valid = (px < w * h) && ($urandom_range(1, 100) <= vld);
      in_data = (px < w * h) ? img[px / w][px % w][7:0] : 8'h00;
      out_ready = ($urandom_range(1, 100) <= rdy);
      ifire = in_valid && w_ir;
      ofire = w_ov && out_ready;
      if (ofire) begin
        if (qw.size() == 0) begin
          chk("extra_win", {199'b0, w_ov}, '0);
        end else begin
          chk("win", w_win, qw[0]);
          chk("row", {192'b0, w_row}, 200'(qr[0]));
          chk("col", {192'b0, w_col}, 200'(qc[0]));
          if (got == 0) first_win = w_win;
          last_win = w_win;
          last_row = int'(w_row);
          last_col = int'(w_col);
          void'(qw.pop_front());
          void'(qr.pop_front());
          void'(qc.pop_front());
          got++;
        end
      end
      stall = w_ov && !out_ready;
      pw = w_win; prow = w_row; pcol = w_col;
      @(posedge clk);
      if (ifire) px++;
      if (abort_n > 0 && got == abort_n) begin
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        start3 = 1'b0; start5 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("abort_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {199'b0, w_bz}, '0);
        return;
      end
      @(negedge clk);
      fin = (qw.size() == 0) && !w_bz;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    start3 = 1'b0; start5 = 1'b0;
    chk("frame_end", {199'b0, w_bz}, '0);
    chk("win_count", 200'(got), 200'(total));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start3 = 1'b0; start5 = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    img_width = '0; img_height = '0; pad_mode = '0; stride = 1'b0;
    sel5 = 1'b0;
    first_win = '0; last_win = '0; last_row = 0; last_col = 0;
    repeat (3) @(negedge clk);
    sel5 = 1'b0;
    check_reset("rst3");
    sel5 = 1'b1;
    check_reset("rst5");
    rst_n = 1'b1;
    @(negedge clk);

    fill_ramp(5, 5);
    run_frame(3, 5, 5, 0, 0, 100, 100, 0, n);
    chk("ramp_p0_cnt", 200'(n), 200'(9));
    chk("ramp_p0_first", first_win, p9(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chk("ramp_p0_centre", {192'b0, last_win[39:32]}, 200'(18));

    run_frame(3, 5, 5, 1, 0, 100, 100, 0, n);
    chk("ramp_p1_cnt", 200'(n), 200'(25));
    chk("ramp_p1_first", first_win, p9(0, 0, 0, 0, 0, 1, 0, 5, 6));

    run_frame(3, 5, 5, 2, 0, 100, 100, 0, n);
    chk("ramp_p2_cnt", 200'(n), 200'(25));
    chk("ramp_p2_lastpos", 200'(last_row * 256 + last_col),
        200'(4 * 256 + 4));
`ifdef WINGEN_EDGE_PAD_EN
    chk("ramp_p2_last", last_win, p9(18, 19, 19, 23, 24, 24, 23, 24, 24));
`else
    chk("ramp_p2_last", last_win, p9(18, 19, 0, 23, 24, 0, 0, 0, 0));
`endif

    fill_ramp(8, 8);
    run_frame(5, 8, 8, 1, 1, 100, 100, 0, n);
    chk("k5_s2_cnt", 200'(n), 200'(16));
    chk("k5_s2_last", 200'(last_row * 256 + last_col), 200'(6 * 256 + 6));

    fill_rand();
    run_frame(3, 7, 6, 2, 1, 30, 60, 0, n);
    chk("rnd_a_cnt", 200'(n), 200'(12));
    fill_rand();
    run_frame(3, 9, 5, 0, 0, 30, 70, 0, n);
    chk("rnd_b_cnt", 200'(n), 200'(21));
    fill_rand();
    run_frame(5, 7, 7, 3, 0, 30, 50, 0, n);
    chk("rnd_c_cnt", 200'(n), 200'(49));
    fill_rand();
    run_frame(5, 9, 8, 0, 1, 30, 80, 0, n);
    chk("rnd_d_cnt", 200'(n), 200'(6));
    fill_rand();
    run_frame(3, 6, 7, 2, 0, 30, 40, 0, n);
    chk("rnd_e_cnt", 200'(n), 200'(42));

    run_frame(3, 2, 5, 0, 0, 100, 100, 0, n);
    chk("bad_narrow_cnt", 200'(n), 200'(0));
    run_frame(5, 40, 8, 1, 0, 100, 100, 0, n);
    chk("bad_wide_cnt", 200'(n), 200'(0));

    fill_rand();
    run_frame(3, 8, 8, 1, 0, 30, 60, 12, n);
    chk("abort_cnt", 200'(n), 200'(12));
    fill_ramp(6, 6);
    run_frame(3, 6, 6, 0, 0, 100, 100, 0, n);
    chk("post_abort_cnt", 200'(n), 200'(16));
    chk("post_abort_first", first_win, p9(0, 1, 2, 6, 7, 8, 12, 13, 14));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
